fifo_rd_prefetch: RTL

FIFO_RD_PREFETCH -- requirements
Module: fifo_rd_prefetch

---
 rtl/fifo_rd_prefetch.sv | 87 ++++++++
 1 files changed

// File: rtl/fifo_rd_prefetch.sv
// Read-side prefetch for an async FIFO: issues RAM reads ahead of the consumer
// and buffers the returning words so dout/dout_valid come straight from registers.
module fifo_rd_prefetch #(
  parameter int unsigned FIFOWIDTH    = 72,
  parameter int unsigned FIFOPTRWIDTH = 4,
  parameter int unsigned RDLAT        = 1,
  localparam int unsigned CNTW        = $clog2(RDLAT + 3)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FIFOPTRWIDTH:0]   numfilled,
  input  logic [FIFOWIDTH-1:0]    rdata,
  input  logic                    dout_ready,
  output logic                    rstb,
  output logic                    dout_valid,
  output logic [FIFOWIDTH-1:0]    dout,
  output logic [CNTW-1:0]         bufcnt
);

  localparam int unsigned BUFDEPTH = RDLAT + 2;
  localparam int unsigned PTRW     = $clog2(BUFDEPTH);
  localparam int unsigned SUMW     = CNTW + 1;

  logic [RDLAT-1:0]     sr_q, sr_d;
  logic [FIFOWIDTH-1:0] mem_q [BUFDEPTH];
  logic [PTRW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNTW-1:0]      cnt_d;
  logic [SUMW-1:0]      inflight;
  logic                 push, pop, valid_d;
  logic [FIFOWIDTH-1:0] dout_d;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(BUFDEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  // Reads already issued but not yet returned.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RDLAT; i++) inflight = inflight + SUMW'(sr_q[i]);
  end

  // Only issue a read when a buffer slot is guaranteed for its return.
  assign rstb = !rst && (numfilled != '0) &&
                ((SUMW'(bufcnt) + inflight) < SUMW'(BUFDEPTH));
  assign push = sr_q[RDLAT-1];
  assign pop  = dout_valid && dout_ready;

  always_comb begin
    sr_d    = RDLAT'({sr_q, rstb});
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = bufcnt;
    valid_d = 1'b0;
    dout_d  = dout;
    if (pop)  head_d = ptr_inc(head_q);
    if (push) tail_d = ptr_inc(tail_q);
    if (push && !pop) cnt_d = bufcnt + CNTW'(1);
    if (!push && pop) cnt_d = bufcnt - CNTW'(1);
    valid_d = (cnt_d != '0);
    // The new head is the word arriving this edge only when it lands in an emptied buffer.
    if (cnt_d != '0) dout_d = (push && (tail_q == head_d)) ? rdata : mem_q[head_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q       <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      bufcnt     <= '0;
      dout_valid <= 1'b0;
      dout       <= '0;
    end else begin
      sr_q       <= sr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      bufcnt     <= cnt_d;
      dout_valid <= valid_d;
      dout       <= dout_d;
    end
  end

  // Data storage needs no reset; validity is carried by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= rdata;
  end

endmodule
